// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu4_core datapath leaf.
//   ALU_W     - native operand/result width
//   opcode_e  - operation codes 0..13; codes 14 and 15 are illegal
package alu_pkg;

   localparam int ALU_W = 4;

   typedef enum logic [3:0] {
      OP_SEL   = 4'd0,
      OP_INC   = 4'd1,
      OP_DEC   = 4'd2,
      OP_ADD   = 4'd3,
      OP_ADD_C = 4'd4,
      OP_SUB   = 4'd5,
      OP_SUB_B = 4'd6,
      OP_AND   = 4'd7,
      OP_OR    = 4'd8,
      OP_XOR   = 4'd9,
      OP_SHL   = 4'd10,
      OP_SHR   = 4'd11,
      OP_ROL   = 4'd12,
      OP_ROR   = 4'd13
   } opcode_e;

endpackage

// File: rtl/alu4_comb.sv
// alu4_comb: purely combinational ALU function.
// Ports:
//   a, b    [WIDTH-1:0] in  operands
//   cin                 in  carry-in (ADD_c) / borrow-in (SUB_b), ignored otherwise
//   ctl     [3:0]       in  opcode (opcode_e values 0..13)
//   result  [WIDTH-1:0] out operation result, modulo 2**WIDTH
//   carry               out carry-out (adds) or borrow-out (subtracts), else 0
//   legal               out 1 when ctl is a defined opcode
module alu4_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       ctl,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             legal
);

   // One extra bit so the adders expose carry-out and the subtractors
   // expose borrow-out (a negative difference wraps and sets the MSB).
   logic [WIDTH:0] ext;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      legal  = 1'b1;
      ext    = '0;
      case (ctl)
         OP_SEL:   result = b;
         OP_INC:   result = b + 1'b1;
         OP_DEC:   result = b - 1'b1;
         OP_ADD: begin
            ext    = {1'b0, a} + {1'b0, b};
            result = ext[WIDTH-1:0];
            carry  = ext[WIDTH];
         end
         OP_ADD_C: begin
            ext    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            result = ext[WIDTH-1:0];
            carry  = ext[WIDTH];
         end
         OP_SUB: begin
            ext    = {1'b0, a} - {1'b0, b};
            result = ext[WIDTH-1:0];
            carry  = ext[WIDTH];
         end
         OP_SUB_B: begin
            ext    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
            result = ext[WIDTH-1:0];
            carry  = ext[WIDTH];
         end
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_SHL:   result = {a[WIDTH-2:0], 1'b0};
         OP_SHR:   result = {1'b0, a[WIDTH-1:1]};
         OP_ROL:   result = {a[WIDTH-2:0], a[WIDTH-1]};
         OP_ROR:   result = {a[0], a[WIDTH-1:1]};
         default:  legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu4_core.sv
// alu4_core: registered 4-bit ALU with a valid handshake and one-cycle latency.
// Ports:
//   clk                   in  rising-edge clock
//   reset                 in  asynchronous active-low reset
//   valid_in              in  operation request, sampled at posedge clk
//   a, b     [WIDTH-1:0]  in  operands
//   cin                   in  carry/borrow-in for ADD_c / SUB_b
//   ctl      [3:0]        in  opcode (opcode_e)
//   valid_out             out one-cycle pulse per accepted legal operation
//   alu      [WIDTH-1:0]  out registered result
//   carry                 out registered carry/borrow
//   zero                  out registered result-is-zero flag
module alu4_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       ctl,
   output logic             valid_out,
   output logic [WIDTH-1:0] alu,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH-1:0] comb_result;
   logic             comb_carry;
   logic             comb_legal;
   logic             take;

   alu4_comb #(.WIDTH(WIDTH)) u_comb (
      .a      (a),
      .b      (b),
      .cin    (cin),
      .ctl    (ctl),
      .result (comb_result),
      .carry  (comb_carry),
      .legal  (comb_legal)
   );

   // Illegal opcodes behave exactly like an idle cycle.
   assign take = valid_in & comb_legal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_out <= 1'b0;
         alu       <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
      end else begin
         valid_out <= take;
         if (take) begin
            alu   <= comb_result;
            carry <= comb_carry;
            zero  <= (comb_result == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu4_core.sv
module tb_alu4_core;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_in;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [3:0] ctl;
   logic       valid_out;
   logic [3:0] alu;
   logic       carry;
   logic       zero;

   int tests  = 0;
   int failed = 0;

   // Expected output state kept by the reference model.
   int exp_valid = 0;
   int exp_alu   = 0;
   int exp_carry = 0;
   int exp_zero  = 0;

   always #5 clk = ~clk;

   alu4_core dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .ctl       (ctl),
      .valid_out (valid_out),
      .alu       (alu),
      .carry     (carry),
      .zero      (zero)
   );

   // Reference ALU in plain integer arithmetic.
   function automatic void model(input int op, input int ia, input int ib, input int ic,
                                 output int res, output int cy, output bit legal);
      int s;
      int d;
      res   = 0;
      cy    = 0;
      legal = 1'b1;
      case (op)
         0:  res = ib;
         1:  res = (ib + 1) % 16;
         2:  res = (ib + 15) % 16;
         3:  begin s = ia + ib;      res = s % 16; cy = (s >= 16) ? 1 : 0; end
         4:  begin s = ia + ib + ic; res = s % 16; cy = (s >= 16) ? 1 : 0; end
         5:  begin d = ia - ib;      res = (d + 16) % 16; cy = (d < 0) ? 1 : 0; end
         6:  begin d = ia - ib - ic; res = (d + 16) % 16; cy = (d < 0) ? 1 : 0; end
         7:  res = ia & ib;
         8:  res = ia | ib;
         9:  res = ia ^ ib;
         10: res = (ia * 2) % 16;
         11: res = ia / 2;
         12: res = (ia * 2) % 16 + ia / 8;
         13: res = ia / 2 + (ia % 2) * 8;
         default: legal = 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input int expv);
      logic [3:0] e;
      e = expv[3:0];
      tests++;
      assert (obs === e) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".valid_out"}, {3'b000, valid_out}, exp_valid);
      chk({tag, ".alu"},       alu,                 exp_alu);
      chk({tag, ".carry"},     {3'b000, carry},     exp_carry);
      chk({tag, ".zero"},      {3'b000, zero},      exp_zero);
   endtask

   // Drive one cycle's inputs at the falling edge, update the model at the
   // rising edge, and compare shortly after that edge.
   task automatic do_op(input bit v, input int op, input int ia, input int ib, input int ic);
      int  res;
      int  cy;
      bit  legal;
      @(negedge clk);
      valid_in = v;
      ctl      = op[3:0];
      a        = ia[3:0];
      b        = ib[3:0];
      cin      = ic[0];
      model(op, ia, ib, ic, res, cy, legal);
      @(posedge clk);
      if (v && legal) begin
         exp_valid = 1;
         exp_alu   = res;
         exp_carry = cy;
         exp_zero  = (res == 0) ? 1 : 0;
      end else begin
         exp_valid = 0;
      end
      #1;
      $display("[TB] t=%0t v=%0d ctl=%0d a=%0d b=%0d cin=%0d -> valid_out=%0d alu=%0d carry=%0d zero=%0d",
               $time, v, op, ia, ib, ic, valid_out, alu, carry, zero);
      chk_all($sformatf("op%0d", op));
   endtask

   task automatic model_reset();
      exp_valid = 0;
      exp_alu   = 0;
      exp_carry = 0;
      exp_zero  = 0;
   endtask

   initial begin
      reset    = 1'b0;
      valid_in = 1'b1;
      a        = 4'd5;
      b        = 4'd5;
      cin      = 1'b1;
      ctl      = 4'd3;
      model_reset();

      // Reset held for two edges with a live request: nothing may escape.
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_all("reset_hold");
      @(negedge clk);
      valid_in = 1'b0;
      reset    = 1'b1;
      #1;
      chk_all("reset_release");

      // ADD with carry-out, then ADD_c producing zero.
      do_op(1, 3, 9, 8, 0);
      do_op(1, 4, 7, 8, 1);
      // SUB_b with borrow, SUB without.
      do_op(1, 6, 3, 3, 1);
      do_op(1, 5, 5, 2, 0);
      // Shift/rotate of 4'b1001 with cin=1 (ignored).
      do_op(1, 10, 9, 0, 1);
      do_op(1, 11, 9, 0, 1);
      do_op(1, 12, 9, 0, 1);
      do_op(1, 13, 9, 0, 1);
      // INC wraps to zero, then idle cycles hold, then illegal opcodes.
      do_op(1, 1, 0, 15, 0);
      do_op(0, 3, 1, 1, 0);
      do_op(0, 3, 1, 1, 0);
      do_op(1, 14, 3, 3, 1);
      do_op(1, 15, 3, 3, 1);
      // DEC wraps below zero.
      do_op(1, 2, 0, 0, 1);

      // Randomized traffic, mostly back-to-back valid.
      for (int i = 0; i < 200; i++) begin
         do_op(($urandom_range(0, 9) < 8), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 1));
      end

      // Asynchronous reset between edges must clear outputs immediately.
      do_op(1, 9, 12, 10, 0);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      $display("[TB] t=%0t async reset -> valid_out=%0d alu=%0d carry=%0d zero=%0d",
               $time, valid_out, alu, carry, zero);
      chk_all("async_reset");
      @(negedge clk);
      reset = 1'b1;
      do_op(1, 8, 5, 10, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
